// File: rtl/core_exu_muldiv.sv
// ---------------------------------------------------------------------------
// core_exu_muldiv -- RISC-V M-extension multiply/divide unit.
//
// Iterative shift-add multiplier and restoring divider that share one
// 2*XLEN accumulator. Each takes XLEN busy cycles. Divide-by-zero and signed
// overflow finish on the accept edge.
//
// Optional feature macro: MULDIV_FAST_MUL_EN
//   When defined, all multiplies finish on the accept edge through a
//   combinational multiplier. Division is not affected.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   mdu_rx_valid     request valid (input)
//   mdu_rx_ready     request ready (output, combinational)
//   mdu_rx_funct3    operation select: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   mdu_rx_rs1/rs2   operands (XLEN)
//   mdu_rx_rd_idx    destination index (RD_W)
//   mdu_flush        discard the in-flight operation
//   mdu_tx_valid     result valid (output)
//   mdu_tx_ready     result ready (input)
//   mdu_tx_res       result (XLEN)
//   mdu_tx_rd_idx    captured destination index
//   mdu_busy         high while iterating
// ---------------------------------------------------------------------------
module core_exu_muldiv #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            mdu_rx_valid,
  output logic            mdu_rx_ready,
  input  logic [2:0]      mdu_rx_funct3,
  input  logic [XLEN-1:0] mdu_rx_rs1,
  input  logic [XLEN-1:0] mdu_rx_rs2,
  input  logic [RD_W-1:0] mdu_rx_rd_idx,
  input  logic            mdu_flush,
  output logic            mdu_tx_valid,
  input  logic            mdu_tx_ready,
  output logic [XLEN-1:0] mdu_tx_res,
  output logic [RD_W-1:0] mdu_tx_rd_idx,
  output logic            mdu_busy
);

  localparam int unsigned CNT_W = (XLEN > 2) ? $clog2(XLEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state, state_nxt;
  logic              rx_accept;
  logic [CNT_W-1:0]  cnt;
  logic              last_step;
  logic [2:0]        f3_q;
  logic              neg_q;
  logic [XLEN-1:0]   op_b;
  logic [XLEN-1:0]   acc_hi, acc_lo;

  // Operand decode at acceptance: signedness, magnitudes and result sign
  logic              rx_is_div, rx_a_signed, rx_b_signed, rx_a_neg, rx_b_neg;
  logic [XLEN-1:0]   rx_a_mag, rx_b_mag;
  logic              rx_div_zero, rx_ovf, rx_fast, rx_quick, rx_neg;
  logic [XLEN-1:0]   rx_quick_res;

  always_comb begin
    rx_is_div   = mdu_rx_funct3[2];
    rx_a_signed = (mdu_rx_funct3 == 3'b001) || (mdu_rx_funct3 == 3'b010) ||
                  (mdu_rx_funct3 == 3'b100) || (mdu_rx_funct3 == 3'b110);
    rx_b_signed = (mdu_rx_funct3 == 3'b001) || (mdu_rx_funct3 == 3'b100) ||
                  (mdu_rx_funct3 == 3'b110);
    rx_a_neg    = rx_a_signed && mdu_rx_rs1[XLEN-1];
    rx_b_neg    = rx_b_signed && mdu_rx_rs2[XLEN-1];
    rx_a_mag    = rx_a_neg ? (~mdu_rx_rs1 + XLEN'(1)) : mdu_rx_rs1;
    rx_b_mag    = rx_b_neg ? (~mdu_rx_rs2 + XLEN'(1)) : mdu_rx_rs2;
    // Remainder follows the dividend sign; everything else uses the sign product
    rx_neg      = (mdu_rx_funct3 == 3'b110) ? rx_a_neg : (rx_a_neg ^ rx_b_neg);
    rx_div_zero = rx_is_div && (mdu_rx_rs2 == '0);
    rx_ovf      = rx_is_div && !mdu_rx_funct3[0] &&
                  (mdu_rx_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (mdu_rx_rs2 == '1);
  end

`ifdef MULDIV_FAST_MUL_EN
  // Extend to 2*XLEN (sign or zero), the low 2*XLEN product bits are exact
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{rx_a_neg}}, mdu_rx_rs1} * {{XLEN{rx_b_neg}}, mdu_rx_rs2};
  assign rx_fast   = !rx_is_div;
`else
  assign rx_fast   = 1'b0;
`endif

  // Result for operations that complete on the accept edge
  always_comb begin
    rx_quick     = rx_div_zero || rx_ovf || rx_fast;
    rx_quick_res = '0;
    if (rx_div_zero)
      rx_quick_res = mdu_rx_funct3[1] ? mdu_rx_rs1 : '1;
    else if (rx_ovf)
      rx_quick_res = mdu_rx_funct3[1] ? '0 : mdu_rx_rs1;
`ifdef MULDIV_FAST_MUL_EN
    else if (mdu_rx_funct3[1:0] == 2'b00)
      rx_quick_res = fast_prod[XLEN-1:0];
    else
      rx_quick_res = fast_prod[2*XLEN-1:XLEN];
`endif
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic [XLEN-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : '0);
    div_sh   = {acc_hi, acc_lo[XLEN-1]};
    div_diff = div_sh - {1'b0, op_b};
    if (!f3_q[2]) begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      step_hi = div_diff[XLEN-1:0];
      step_lo = {acc_lo[XLEN-2:0], 1'b1};
    end else begin
      step_hi = div_sh[XLEN-1:0];
      step_lo = {acc_lo[XLEN-2:0], 1'b0};
    end
  end

  // Sign fix-up and result selection after the final step
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, final_res;

  always_comb begin
    prod_s = neg_q ? (~{step_hi, step_lo} + (2*XLEN)'(1)) : {step_hi, step_lo};
    quo_s  = neg_q ? (~step_lo + XLEN'(1)) : step_lo;
    rem_s  = neg_q ? (~step_hi + XLEN'(1)) : step_hi;
    if (!f3_q[2])
      final_res = (f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    else
      final_res = f3_q[1] ? rem_s : quo_s;
  end

  assign last_step = (cnt == CNT_W'(XLEN-1));

  // Next state, ready and accept; flush overrides everything
  always_comb begin
    state_nxt    = state;
    mdu_rx_ready = 1'b0;
    case (state)
      S_IDLE:  mdu_rx_ready = 1'b1;
      S_DONE:  mdu_rx_ready = mdu_tx_ready;
      default: mdu_rx_ready = 1'b0;
    endcase
    if (mdu_flush) mdu_rx_ready = 1'b0;
    rx_accept = mdu_rx_valid && mdu_rx_ready;
    case (state)
      S_IDLE: if (rx_accept) state_nxt = rx_quick ? S_DONE : S_BUSY;
      S_BUSY: if (last_step) state_nxt = S_DONE;
      S_DONE: if (mdu_tx_ready)
                state_nxt = rx_accept ? (rx_quick ? S_DONE : S_BUSY) : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (mdu_flush) state_nxt = S_IDLE;
  end

  // State register with registered status outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      mdu_tx_valid <= 1'b0;
      mdu_busy     <= 1'b0;
    end else begin
      state        <= state_nxt;
      mdu_tx_valid <= (state_nxt == S_DONE);
      mdu_busy     <= (state_nxt == S_BUSY);
    end
  end

  // Operand capture, iteration and result register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt           <= '0;
      f3_q          <= '0;
      neg_q         <= 1'b0;
      op_b          <= '0;
      acc_hi        <= '0;
      acc_lo        <= '0;
      mdu_tx_res    <= '0;
      mdu_tx_rd_idx <= '0;
    end else if (rx_accept) begin
      cnt           <= '0;
      f3_q          <= mdu_rx_funct3;
      neg_q         <= rx_neg;
      op_b          <= rx_is_div ? rx_b_mag : rx_a_mag;
      acc_hi        <= '0;
      acc_lo        <= rx_is_div ? rx_a_mag : rx_b_mag;
      mdu_tx_rd_idx <= mdu_rx_rd_idx;
      if (rx_quick) mdu_tx_res <= rx_quick_res;
    end else if ((state == S_BUSY) && !mdu_flush) begin
      cnt    <= cnt + CNT_W'(1);
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      if (last_step) mdu_tx_res <= final_res;
    end
  end

endmodule

// File: doc/core_exu_muldiv.md
CORE_EXU_MULDIV -- requirements
Module: core_exu_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width (even, >=8).
REQ-002 SHALL have parameter RD_W, default 5, meaning destination register index width.
REQ-003 SHALL have ports: clk  input  1  rising-edge clock; one clock only.
REQ-004 SHALL have rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have mdu_rx_valid  input  1  upstream request valid.
REQ-006 SHALL have mdu_rx_ready  output  1  request accepted when valid&&ready.
REQ-007 SHALL have mdu_rx_funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have mdu_rx_rs1, mdu_rx_rs2  input  XLEN  operands; mdu_rx_rd_idx  input  RD_W  destination index.
REQ-009 SHALL have mdu_flush  input  1  discard in-flight operation.
REQ-010 SHALL have mdu_tx_valid  output  1; mdu_tx_ready  input  1  downstream handshake.
REQ-011 SHALL have mdu_tx_res  output  XLEN  result; mdu_tx_rd_idx  output  RD_W  captured index; mdu_busy  output  1  high in S_BUSY.

Function
REQ-012 SHALL implement FSM S_IDLE, S_BUSY, S_DONE; mdu_tx_valid = (state==S_DONE).
REQ-013 mdu_rx_ready SHALL be 1 in S_IDLE, (mdu_tx_ready) in S_DONE, 0 in S_BUSY, and 0 whenever mdu_flush=1.
REQ-014 On acceptance SHALL register funct3, operands and rd_idx; inputs ignored afterwards.
REQ-015 Normal ops: S_IDLE/S_DONE -> S_BUSY on accept; S_BUSY lasts exactly XLEN cycles (one shift-add or restoring-subtract step per cycle); then S_DONE; mdu_tx_valid rises XLEN+1 edges after the accept edge.
REQ-016 Short-circuit: divisor zero or signed overflow (DIV/REM, rs1=most-negative, rs2=-1) SHALL go directly to S_DONE on the accept edge (latency 1).
REQ-017 Divide by zero: DIV/DIVU SHALL return all-ones; REM/REMU SHALL return rs1.
REQ-018 Signed overflow: DIV SHALL return rs1; REM SHALL return 0.
REQ-019 Signed division SHALL iterate on magnitudes; quotient negated when operand signs differ; remainder takes sign of dividend.
REQ-020 MUL SHALL return low XLEN bits; MULH/MULHSU/MULHU SHALL return high XLEN bits of the 2*XLEN product with operands signed/signed, signed/unsigned, unsigned/unsigned.
REQ-021 S_DONE holds mdu_tx_res/mdu_tx_rd_idx stable until tx handshake; on handshake without new accept -> S_IDLE; with simultaneous accept -> new op starts that edge (no bubble).
REQ-022 mdu_flush=1 SHALL force next state S_IDLE from any state, clear mdu_tx_valid next edge, and take priority over any same-cycle handshake; mdu_tx_res keeps last value.
REQ-023 mdu_tx_valid SHALL never fall without mdu_tx_ready or mdu_flush.

Reset
REQ-024 rstn low SHALL asynchronously force S_IDLE, mdu_tx_valid=0, mdu_busy=0, mdu_tx_res=0, mdu_tx_rd_idx=0, iteration counter=0, including mid-operation.
REQ-025 After rstn deasserts, mdu_rx_ready SHALL be 1 in the first cycle (absent flush).

Configuration
REQ-026 Macro MULDIV_FAST_MUL_EN: when defined, MUL/MULH/MULHSU/MULHU SHALL complete via a single-cycle combinational 2*XLEN multiplier, going directly to S_DONE on accept (latency 1); division unchanged.
REQ-027 When undefined, all multiplies SHALL use the XLEN-cycle iterative path of REQ-015 and no combinational multiplier SHALL be instantiated.

Verification (XLEN=32, macro undefined unless stated)
REQ-028 DIV rs1=0xFFFFFFF9 (-7), rs2=2, rd=5 -> tx_valid 33 cycles after accept, res=0xFFFFFFFD, rd_idx=5; REM same operands -> 0xFFFFFFFF.
REQ-029 DIVU rs1=0x1234, rs2=0 -> res=0xFFFFFFFF next cycle; REMU -> 0x00001234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-030 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MUL 7*6 -> 0x2A; with MULDIV_FAST_MUL_EN same results at latency 1.
REQ-031 tx_ready held 0 for 10 cycles in S_DONE -> tx_valid/res stable; then tx_ready=1 with rx_valid=1 -> next op accepted same edge, busy next cycle.
REQ-032 Flush at BUSY cycle 10 with rx_valid=1 -> rx_ready=0, S_IDLE next edge, no tx_valid; rstn pulse low mid-BUSY -> all outputs at reset values immediately.
